load_store_unit: RTL and testbench

// - Sits between the execute stage and data_memory. Turns RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW)

---
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: maps byte/half/word accesses onto a word-only data memory port.
// Sub-word stores take a read-modify-write through the RMW_WR state.
module load_store_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  load_valid,
  output logic [XLEN-1:0]       load_data,
  output logic                  access_error,
  output logic [ADDR_WIDTH-1:0] mem_byte_address,
  output logic                  mem_write_enable,
  output logic [XLEN-1:0]       mem_write_data,
  input  logic [XLEN-1:0]       mem_read_data
);

  // state  | meaning
  // IDLE   | accepting requests; SW and loads complete here
  // RMW_WR | writing the merged word latched during the SB/SH read cycle
  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
  logic [XLEN-1:0]       rmw_data_q, rmw_data_d;
  logic [XLEN-1:0]       load_data_q, load_data_d;
  logic                  load_valid_q, load_valid_d;
  logic                  access_error_q, access_error_d;

  logic                  is_half, is_word, misaligned, req_err;
  logic [XLEN-1:0]       rd_shift, load_ext, merged;

  // Addresses wrap at ADDR_WIDTH; the upper request bits are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH];

  assign is_half    = (req_funct3[1:0] == 2'b01);
  assign is_word    = (req_funct3 == 3'b010);
  assign misaligned = (is_half & req_addr[0]) | (is_word & (|req_addr[1:0]));

  always_comb begin
    req_err = misaligned;
    if (req_is_store) begin
      if (req_funct3[2] || req_funct3 == 3'b011) req_err = 1'b1;
    end else begin
      if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) req_err = 1'b1;
    end
  end

  assign rd_shift = mem_read_data >> {req_addr[1:0], 3'b000};

  always_comb begin
    load_ext = mem_read_data;
    case (req_funct3)
      3'b000:  load_ext = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
      default: load_ext = mem_read_data;
    endcase
  end

  always_comb begin
    merged = mem_read_data;
    if (req_funct3[1:0] == 2'b00)
      merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
    else
      merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
  end

  always_comb begin
    state_d          = state_q;
    rmw_addr_d       = rmw_addr_q;
    rmw_data_d       = rmw_data_q;
    load_data_d      = load_data_q;
    load_valid_d     = 1'b0;
    access_error_d   = 1'b0;
    req_ready        = 1'b0;
    mem_byte_address = req_addr[ADDR_WIDTH-1:0];
    mem_write_enable = 1'b0;
    mem_write_data   = req_wdata;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err) begin
            access_error_d = 1'b1;
          end else if (req_is_store) begin
            if (is_word) begin
              mem_write_enable = 1'b1;
            end else begin
              rmw_addr_d = req_addr[ADDR_WIDTH-1:0];
              rmw_data_d = merged;
              state_d    = RMW_WR;
            end
          end else begin
            load_valid_d = 1'b1;
            load_data_d  = load_ext;
          end
        end
      end
      RMW_WR: begin
        mem_byte_address = rmw_addr_q;
        mem_write_data   = rmw_data_q;
        mem_write_enable = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rmw_addr_q     <= '0;
      rmw_data_q     <= '0;
      load_data_q    <= '0;
      load_valid_q   <= 1'b0;
      access_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rmw_addr_q     <= rmw_addr_d;
      rmw_data_q     <= rmw_data_d;
      load_data_q    <= load_data_d;
      load_valid_q   <= load_valid_d;
      access_error_q <= access_error_d;
    end
  end

  assign load_valid   = load_valid_q;
  assign load_data    = load_data_q;
  assign access_error = access_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a combinational-read word memory model.
// Directed accesses push expected responses and writes; a monitor pops and compares.
module tb_load_store_unit;

  localparam int K_LOAD = 0;
  localparam int K_ERR  = 1;
  localparam int K_SW   = 2;
  localparam int K_RMW  = 3;
  localparam int K_NONE = 4;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        load_valid;
  logic [31:0] load_data;
  logic        access_error;
  logic [9:0]  mem_byte_address;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [256] = '{default: 32'h0};

  int tests = 0;
  int fails = 0;
  int last_stalls = 0;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_byte_address[9:2]];
  always @(posedge clk) if (mem_write_enable) mem[mem_byte_address[9:2]] <= mem_write_data;

  load_store_unit #(.ADDR_WIDTH(10), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .load_valid(load_valid), .load_data(load_data), .access_error(access_error),
    .mem_byte_address(mem_byte_address), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  // Holds the request until accepted; the expectation is pushed at the acceptance sample.
  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int kind, input logic [31:0] exp);
    rsp_t r;
    wr_t  w;
    int   n;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    last_stalls = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      last_stalls++;
      n++;
      if (n > 20) begin
        flag("accept_timeout");
        break;
      end
    end
    if (kind == K_LOAD || kind == K_ERR) begin
      r.is_err = (kind == K_ERR);
      r.data   = exp;
      rsp_q.push_back(r);
    end else if (kind == K_SW || kind == K_RMW) begin
      w.addr = a[9:0];
      w.data = exp;
      wr_q.push_back(w);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin : monitor
    rsp_t r;
    wr_t  w;
    forever begin
      @(negedge clk); #1;
      if (rst_n) begin
        if (load_valid && access_error) flag("valid_and_error_both_high");
        if (load_valid || access_error) begin
          if (rsp_q.size() == 0) begin
            flag("unexpected_response");
          end else begin
            r = rsp_q.pop_front();
            chk("rsp_kind_is_error", {31'h0, access_error}, {31'h0, r.is_err});
            if (!r.is_err) chk("load_data", load_data, r.data);
          end
        end
        if (mem_write_enable) begin
          if (wr_q.size() == 0) begin
            flag("unexpected_mem_write");
          end else begin
            w = wr_q.pop_front();
            chk("write_addr", {22'h0, mem_byte_address}, {22'h0, w.addr});
            chk("write_data", mem_write_data, w.data);
          end
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_load_valid", {31'h0, load_valid}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_access_error", {31'h0, access_error}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mem_we", {31'h0, mem_write_enable}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while the SB write is pending: the word must be left alone.
    issue(1, 3'b010, 32'h000, 32'h55667788, K_SW, 32'h55667788);
    issue(1, 3'b000, 32'h001, 32'h000000AA, K_NONE, 32'h0);
    #1 rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rmw_reset_word", mem[0], 32'h55667788);
    chk("mid_rmw_reset_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;

    issue(1, 3'b010, 32'h008, 32'h11223344, K_SW, 32'h11223344);
    issue(0, 3'b010, 32'h008, 32'h0, K_LOAD, 32'h11223344);

    issue(1, 3'b000, 32'h00A, 32'h000000AA, K_RMW, 32'h11AA3344);
    issue(0, 3'b000, 32'h00A, 32'h0, K_LOAD, 32'hFFFFFFAA);
    chk("sb_stall_cycles", last_stalls, 32'd1);
    chk("sb_mem_word", mem[2], 32'h11AA3344);
    issue(0, 3'b100, 32'h00A, 32'h0, K_LOAD, 32'h000000AA);

    issue(1, 3'b001, 32'h00E, 32'h00008001, K_RMW, 32'h80010000);
    issue(0, 3'b001, 32'h00E, 32'h0, K_LOAD, 32'hFFFF8001);
    chk("sh_stall_cycles", last_stalls, 32'd1);
    chk("sh_mem_word", mem[3], 32'h80010000);
    issue(0, 3'b101, 32'h00E, 32'h0, K_LOAD, 32'h00008001);

    issue(0, 3'b010, 32'h006, 32'h0, K_ERR, 32'h0);
    issue(1, 3'b001, 32'h003, 32'h0000BEEF, K_ERR, 32'h0);
    issue(0, 3'b011, 32'h000, 32'h0, K_ERR, 32'h0);
    issue(1, 3'b100, 32'h004, 32'h0, K_ERR, 32'h0);
    @(negedge clk);
    chk("load_data_held_after_errors", load_data, 32'h00008001);
    chk("mem_untouched_by_errors", mem[0], 32'h55667788);
    @(posedge clk); #1;

    issue(1, 3'b010, 32'h010, 32'hDEADBEEF, K_SW, 32'hDEADBEEF);
    chk("b2b_sw_stall", last_stalls, 32'd0);
    issue(1, 3'b000, 32'h011, 32'h00000012, K_RMW, 32'hDEAD12EF);
    chk("b2b_sb_stall", last_stalls, 32'd0);
    issue(0, 3'b010, 32'h010, 32'h0, K_LOAD, 32'hDEAD12EF);
    chk("b2b_lw_stall", last_stalls, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("rsp_queue_drained", rsp_q.size(), 32'd0);
    chk("wr_queue_drained", wr_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
